// File: rtl/wb_vbuf_cache_if.sv
// Pipeline-side (mem_*) and memory-side (pmem_*) buses of the write-back cache.
// slave = cache view (serves mem_*, drives pmem_*); master = surrounding logic view.
interface wb_vbuf_cache_if #(
    parameter int S_OFFSET = 5
);
    localparam int S_MASK = 2**S_OFFSET;
    localparam int S_LINE = 8*S_MASK;

    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [S_MASK-1:0] mem_byte_enable256;
    logic [S_LINE-1:0] mem_wdata256;
    logic [S_LINE-1:0] mem_rdata256;
    logic              mem_resp;

    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
        output mem_rdata256, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256,
        input  mem_rdata256, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/wb_vbuf_cache.sv
// N-way set-associative write-back cache, tree-PLRU, one-entry victim buffer.
// Latency: hits respond combinationally; misses take memory latency + 2 cycles.
// Backpressure: requests are held until mem_resp; pmem requests held until pmem_resp.
module wb_vbuf_cache #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 4,
    parameter int NUM_WAYS = 4
) (
    input  logic           clk,
    input  logic           rst,
    wb_vbuf_cache_if.slave bus
);
    localparam int S_TAG  = 32 - S_OFFSET - S_INDEX;
    localparam int S_MASK = 2**S_OFFSET;
    localparam int S_LINE = 8*S_MASK;
    localparam int SETS   = 2**S_INDEX;
    localparam int W_WAY  = $clog2(NUM_WAYS);
    localparam int N_PLRU = NUM_WAYS - 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
    state_t state_q, state_d;

    logic [S_TAG-1:0]  tag_q   [NUM_WAYS][SETS];
    logic [S_LINE-1:0] line_q  [NUM_WAYS][SETS];
    logic              valid_q [NUM_WAYS][SETS];
    logic              dirty_q [NUM_WAYS][SETS];
    logic [N_PLRU-1:0] plru_q  [SETS];
    logic              vb_vld_q;
    logic [31:0]       vb_addr_q;
    logic [S_LINE-1:0] vb_line_q;
    logic [W_WAY-1:0]  fill_way_q;

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [31:0]        req_line_addr;
    logic               req;
    logic               hit;
    logic [W_WAY-1:0]   hit_way;
    logic [W_WAY-1:0]   victim_way;
    logic               victim_dirty;
    logic [S_LINE-1:0]  hit_line;
    logic [S_LINE-1:0]  merged_line;
    logic               take_fill;
    logic               fill_done;
    logic               drain_done;
    logic               unused_ok;

    assign req_tag       = bus.mem_address[31 -: S_TAG];
    assign req_idx       = bus.mem_address[S_OFFSET +: S_INDEX];
    assign req_line_addr = {bus.mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
    assign req           = bus.mem_read | bus.mem_write;
    assign unused_ok     = ^bus.mem_address[S_OFFSET-1:0];

    // Every node on the path is turned to point away from the accessed way.
    function automatic logic [N_PLRU-1:0] plru_touch(input logic [N_PLRU-1:0] cur,
                                                     input logic [W_WAY-1:0]  way);
        logic [N_PLRU-1:0] nxt;
        logic              dir;
        int                node;
        nxt  = cur;
        node = 0;
        for (int l = 0; l < W_WAY; l++) begin
            dir = way[W_WAY-1-l];
            for (int n = 0; n < N_PLRU; n++)
                if (n == node) nxt[n] = ~dir;
            node = 2*node + 1 + int'(dir);
        end
        return nxt;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = W_WAY'(w);
            end
    end

    // Lowest invalid way wins; otherwise walk the PLRU tree (bit=0 -> left half).
    always_comb begin
        int   node;
        logic bit_sel;
        node = 0;
        for (int l = 0; l < W_WAY; l++) begin
            bit_sel = 1'b0;
            for (int n = 0; n < N_PLRU; n++)
                if (n == node) bit_sel = plru_q[req_idx][n];
            node = 2*node + 1 + int'(bit_sel);
        end
        victim_way = W_WAY'(node - N_PLRU);
        for (int w = NUM_WAYS-1; w >= 0; w--)
            if (!valid_q[w][req_idx]) victim_way = W_WAY'(w);
    end

    assign victim_dirty = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];
    assign hit_line     = line_q[hit_way][req_idx];

    always_comb begin
        merged_line = hit_line;
        for (int b = 0; b < S_MASK; b++)
            if (bus.mem_byte_enable256[b]) merged_line[8*b +: 8] = bus.mem_wdata256[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    // A request for the parked line must see the writeback land first.
                    if (vb_vld_q && req_line_addr == vb_addr_q) state_d = DRAIN;
                    else if (vb_vld_q && victim_dirty)          state_d = DRAIN;
                    else                                        state_d = FILL;
                end else if (!req && vb_vld_q) begin
                    state_d = DRAIN;
                end
            end
            FILL:    if (bus.pmem_resp) state_d = IDLE;
            DRAIN:   if (bus.pmem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_resp     = req && hit && (state_q != FILL);
        bus.mem_rdata256 = hit_line;
        bus.pmem_read    = (state_q == FILL);
        bus.pmem_write   = (state_q == DRAIN);
        bus.pmem_wdata   = vb_line_q;
        bus.pmem_address = '0;
        if (state_q == FILL)  bus.pmem_address = req_line_addr;
        if (state_q == DRAIN) bus.pmem_address = vb_addr_q;
    end

    assign take_fill  = (state_q == IDLE) && req && !hit && (state_d == FILL);
    assign fill_done  = (state_q == FILL) && bus.pmem_resp;
    assign drain_done = (state_q == DRAIN) && bus.pmem_resp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < NUM_WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            vb_vld_q   <= 1'b0;
            fill_way_q <= '0;
        end else begin
            if (bus.mem_resp) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                if (bus.mem_write) dirty_q[hit_way][req_idx] <= 1'b1;
            end
            if (take_fill) begin
                fill_way_q <= victim_way;
                if (victim_dirty) begin
                    vb_vld_q                     <= 1'b1;
                    dirty_q[victim_way][req_idx] <= 1'b0;
                    valid_q[victim_way][req_idx] <= 1'b0;
                end
            end
            if (fill_done) begin
                valid_q[fill_way_q][req_idx] <= 1'b1;
                dirty_q[fill_way_q][req_idx] <= 1'b0;
            end
            if (drain_done) vb_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (take_fill && victim_dirty) begin
            vb_line_q <= line_q[victim_way][req_idx];
            vb_addr_q <= {tag_q[victim_way][req_idx], req_idx, {S_OFFSET{1'b0}}};
        end
        if (fill_done) begin
            line_q[fill_way_q][req_idx] <= bus.pmem_rdata;
            tag_q[fill_way_q][req_idx]  <= req_tag;
        end
        if (bus.mem_resp && bus.mem_write) line_q[hit_way][req_idx] <= merged_line;
    end
endmodule
